// File: rtl/next_pc_predictor_pkg.sv
// Shared encodings for the next-PC predictor: execute-stage instruction types,
// branch condition codes and 2-bit saturating counter states.
package next_pc_predictor_pkg;

  typedef enum logic [1:0] {
    EX_NONE   = 2'd0,
    EX_BRANCH = 2'd1,
    EX_JAL    = 2'd2,
    EX_JALR   = 2'd3
  } ex_type_e;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  // Saturating step toward taken / not-taken.
  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    if (taken) return (ctr == CTR_ST)  ? ctr : ctr + 2'd1;
    else       return (ctr == CTR_SNT) ? ctr : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/next_pc_predictor_resolver.sv
// Combinational execute-stage resolution of BRANCH/JAL/JALR: actual direction,
// actual target, link value and mispredict against the carried prediction.
module next_pc_predictor_resolver
  import next_pc_predictor_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int IMM_SHIFT = 0
) (
  input  logic            ex_valid_i,
  input  logic [1:0]      ex_type_i,
  input  logic [2:0]      ex_funct3_i,
  input  logic [XLEN-1:0] ex_pc_i,
  input  logic [XLEN-1:0] ex_rs1_i,
  input  logic [XLEN-1:0] ex_rs2_i,
  input  logic [XLEN-1:0] ex_imm_i,
  input  logic            ex_pred_taken_i,
  input  logic [XLEN-1:0] ex_pred_target_i,
  output logic            resolved_o,
  output logic            taken_o,
  output logic [XLEN-1:0] target_o,
  output logic [XLEN-1:0] redirect_o,
  output logic [XLEN-1:0] link_o,
  output logic            mispredict_o
);

  logic [XLEN-1:0] pc_rel_target;
  logic [XLEN-1:0] jalr_sum;
  logic            cond_true;

  assign pc_rel_target = ex_pc_i + (ex_imm_i << IMM_SHIFT);
  assign jalr_sum      = ex_rs1_i + ex_imm_i;
  assign link_o        = ex_pc_i + XLEN'(4);

  always_comb begin
    cond_true = 1'b0;
    case (ex_funct3_i)
      F3_BEQ:  cond_true = (ex_rs1_i == ex_rs2_i);
      F3_BNE:  cond_true = (ex_rs1_i != ex_rs2_i);
      F3_BLT:  cond_true = ($signed(ex_rs1_i) <  $signed(ex_rs2_i));
      F3_BGE:  cond_true = ($signed(ex_rs1_i) >= $signed(ex_rs2_i));
      F3_BLTU: cond_true = (ex_rs1_i <  ex_rs2_i);
      F3_BGEU: cond_true = (ex_rs1_i >= ex_rs2_i);
      default: cond_true = 1'b0;
    endcase
  end

  // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    resolved_o = ex_valid_i && (ex_type_e'(ex_type_i) != EX_NONE);
    taken_o    = 1'b0;
    target_o   = pc_rel_target;
    case (ex_type_e'(ex_type_i))
      EX_BRANCH: taken_o = cond_true;
      EX_JAL:    taken_o = 1'b1;
      EX_JALR: begin
        taken_o  = 1'b1;
        target_o = {jalr_sum[XLEN-1:1], 1'b0};
      end
      default:   taken_o = 1'b0;
    endcase
    if (!resolved_o) taken_o = 1'b0;

    mispredict_o = resolved_o &&
                   ((taken_o != ex_pred_taken_i) ||
                    (taken_o && (target_o != ex_pred_target_i)));
    redirect_o   = taken_o ? target_o : link_o;
  end

endmodule

// File: rtl/next_pc_predictor.sv
// Fetch PC register plus direct-mapped BTB with 2-bit counters; redirects fetch
// when the execute-stage resolver reports a mispredict.
module next_pc_predictor
  import next_pc_predictor_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter int              BTB_DEPTH = 16,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter int              IMM_SHIFT = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_i,
  output logic [XLEN-1:0] pc_o,
  output logic            pred_taken_o,
  output logic [XLEN-1:0] pred_target_o,
  input  logic            ex_valid_i,
  input  logic [1:0]      ex_type_i,
  input  logic [2:0]      ex_funct3_i,
  input  logic [XLEN-1:0] ex_pc_i,
  input  logic [XLEN-1:0] ex_rs1_i,
  input  logic [XLEN-1:0] ex_rs2_i,
  input  logic [XLEN-1:0] ex_imm_i,
  input  logic            ex_pred_taken_i,
  input  logic [XLEN-1:0] ex_pred_target_i,
  output logic            flush_o,
  output logic [XLEN-1:0] link_o
);

  localparam int IDX   = $clog2(BTB_DEPTH);
  localparam int TAG_W = XLEN - 2 - IDX;

  logic [XLEN-1:0]  pc_q, pc_d;
  logic             btb_valid_q  [BTB_DEPTH];
  logic             btb_valid_d  [BTB_DEPTH];
  logic [TAG_W-1:0] btb_tag_q    [BTB_DEPTH];
  logic [TAG_W-1:0] btb_tag_d    [BTB_DEPTH];
  logic [XLEN-1:0]  btb_target_q [BTB_DEPTH];
  logic [XLEN-1:0]  btb_target_d [BTB_DEPTH];
  logic [1:0]       btb_ctr_q    [BTB_DEPTH];
  logic [1:0]       btb_ctr_d    [BTB_DEPTH];

  logic             res_valid, res_taken;
  logic [XLEN-1:0]  res_target, res_redirect;

  next_pc_predictor_resolver #(
    .XLEN      (XLEN),
    .IMM_SHIFT (IMM_SHIFT)
  ) u_resolver (
    .ex_valid_i       (ex_valid_i),
    .ex_type_i        (ex_type_i),
    .ex_funct3_i      (ex_funct3_i),
    .ex_pc_i          (ex_pc_i),
    .ex_rs1_i         (ex_rs1_i),
    .ex_rs2_i         (ex_rs2_i),
    .ex_imm_i         (ex_imm_i),
    .ex_pred_taken_i  (ex_pred_taken_i),
    .ex_pred_target_i (ex_pred_target_i),
    .resolved_o       (res_valid),
    .taken_o          (res_taken),
    .target_o         (res_target),
    .redirect_o       (res_redirect),
    .link_o           (link_o),
    .mispredict_o     (flush_o)
  );

  // Fetch-side lookup reads registered contents only, so an update at the
  // same index in this cycle is not visible until after the edge.
  logic [IDX-1:0]   fetch_idx;
  logic [TAG_W-1:0] fetch_tag;
  logic             fetch_hit;

  assign pc_o          = pc_q;
  assign fetch_idx     = pc_q[2 +: IDX];
  assign fetch_tag     = pc_q[XLEN-1 -: TAG_W];
  assign fetch_hit     = btb_valid_q[fetch_idx] && (btb_tag_q[fetch_idx] == fetch_tag);
  assign pred_taken_o  = fetch_hit && btb_ctr_q[fetch_idx][1];
  assign pred_target_o = fetch_hit ? btb_target_q[fetch_idx] : '0;

  always_comb begin
    if (flush_o)           pc_d = res_redirect;
    else if (stall_i)      pc_d = pc_q;
    else if (pred_taken_o) pc_d = pred_target_o;
    else                   pc_d = pc_q + XLEN'(4);
  end

  logic [IDX-1:0]   ex_idx;
  logic [TAG_W-1:0] ex_tag;
  logic             ex_hit;

  assign ex_idx = ex_pc_i[2 +: IDX];
  assign ex_tag = ex_pc_i[XLEN-1 -: TAG_W];
  assign ex_hit = btb_valid_q[ex_idx] && (btb_tag_q[ex_idx] == ex_tag);

  always_comb begin
    btb_valid_d  = btb_valid_q;
    btb_tag_d    = btb_tag_q;
    btb_target_d = btb_target_q;
    btb_ctr_d    = btb_ctr_q;
    if (res_valid) begin
      if (ex_hit) begin
        btb_ctr_d[ex_idx] = ctr_next(btb_ctr_q[ex_idx], res_taken);
        if (res_taken) btb_target_d[ex_idx] = res_target;
      end else if (res_taken) begin
        btb_valid_d[ex_idx]  = 1'b1;
        btb_tag_d[ex_idx]    = ex_tag;
        btb_target_d[ex_idx] = res_target;
        btb_ctr_d[ex_idx]    = CTR_WT;
      end
    end
  end

  // NOTE: state flops use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_q <= RESET_PC;
    else        pc_q <= pc_d;
  end

  // NOTE: the BTB is built from flops, so the whole array is cleared on reset; tags and
  // targets are cleared too so no stale entry content survives a mid-run reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BTB_DEPTH; i++) begin
        btb_valid_q[i]  <= 1'b0;
        btb_tag_q[i]    <= '0;
        btb_target_q[i] <= '0;
        btb_ctr_q[i]    <= CTR_WNT;
      end
    end else begin
      btb_valid_q  <= btb_valid_d;
      btb_tag_q    <= btb_tag_d;
      btb_target_q <= btb_target_d;
      btb_ctr_q    <= btb_ctr_d;
    end
  end

endmodule

// File: tb/tb_next_pc_predictor.sv
// Self-checking bench for next_pc_predictor: directed table, hand-written
// corner sequences and randomized traffic against a behavioural model.
module tb_next_pc_predictor;

  localparam logic [31:0] RST_PC = 32'h100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        stall_i = 1'b0;
  logic [31:0] pc_o, pred_target_o, link_o;
  logic        pred_taken_o, flush_o;
  logic        ex_valid_i = 1'b0;
  logic [1:0]  ex_type_i = 2'd0;
  logic [2:0]  ex_funct3_i = 3'd0;
  logic [31:0] ex_pc_i = '0, ex_rs1_i = '0, ex_rs2_i = '0, ex_imm_i = '0;
  logic        ex_pred_taken_i = 1'b0;
  logic [31:0] ex_pred_target_i = '0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  next_pc_predictor #(
    .XLEN(32), .BTB_DEPTH(16), .RESET_PC(RST_PC), .IMM_SHIFT(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i),
    .pc_o(pc_o), .pred_taken_o(pred_taken_o), .pred_target_o(pred_target_o),
    .ex_valid_i(ex_valid_i), .ex_type_i(ex_type_i), .ex_funct3_i(ex_funct3_i),
    .ex_pc_i(ex_pc_i), .ex_rs1_i(ex_rs1_i), .ex_rs2_i(ex_rs2_i), .ex_imm_i(ex_imm_i),
    .ex_pred_taken_i(ex_pred_taken_i), .ex_pred_target_i(ex_pred_target_i),
    .flush_o(flush_o), .link_o(link_o)
  );

  // ---------------- behavioural model ----------------
  logic [31:0] m_pc;
  bit          m_v   [16];
  logic [31:0] m_tag [16];
  logic [31:0] m_tgt [16];
  int          m_ctr [16];

  function automatic int m_idx(input logic [31:0] a);
    return int'((a >> 2) & 32'hF);
  endfunction

  task automatic model_reset();
    m_pc = RST_PC;
    for (int i = 0; i < 16; i++) begin
      m_v[i] = 0; m_tag[i] = '0; m_tgt[i] = '0; m_ctr[i] = 1;
    end
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Checks all outputs against the model, then advances one clock edge.
  task automatic cycle(input string nm);
    int          i, j;
    bit          hit, ptk, res, tk, fl;
    logic [31:0] ptgt, tgt, link, npc;
    @(negedge clk);
    i    = m_idx(m_pc);
    hit  = m_v[i] && (m_tag[i] == (m_pc >> 6));
    ptk  = hit && (m_ctr[i] >= 2);
    ptgt = hit ? m_tgt[i] : 32'h0;
    res  = ex_valid_i && (ex_type_i != 2'd0);
    tk   = 0;
    tgt  = ex_pc_i + ex_imm_i;
    case (ex_type_i)
      2'd1: case (ex_funct3_i)
              3'b000: tk = (ex_rs1_i == ex_rs2_i);
              3'b001: tk = (ex_rs1_i != ex_rs2_i);
              3'b100: tk = (int'(ex_rs1_i) <  int'(ex_rs2_i));
              3'b101: tk = (int'(ex_rs1_i) >= int'(ex_rs2_i));
              3'b110: tk = (ex_rs1_i <  ex_rs2_i);
              3'b111: tk = (ex_rs1_i >= ex_rs2_i);
              default: tk = 0;
            endcase
      2'd2: tk = 1;
      2'd3: begin tk = 1; tgt = (ex_rs1_i + ex_imm_i) & 32'hFFFF_FFFE; end
      default: tk = 0;
    endcase
    if (!res) tk = 0;
    link = ex_pc_i + 32'd4;
    fl   = res && ((tk != ex_pred_taken_i) || (tk && (tgt != ex_pred_target_i)));
    check({nm, ".pc"},          pc_o,          m_pc);
    check({nm, ".pred_taken"},  32'(pred_taken_o), 32'(ptk));
    check({nm, ".pred_target"}, pred_target_o, ptgt);
    check({nm, ".flush"},       32'(flush_o),  32'(fl));
    check({nm, ".link"},        link_o,        link);
    if (fl)           npc = tk ? tgt : link;
    else if (stall_i) npc = m_pc;
    else if (ptk)     npc = ptgt;
    else              npc = m_pc + 32'd4;
    j = m_idx(ex_pc_i);
    @(posedge clk);
    m_pc = npc;
    if (res) begin
      if (m_v[j] && (m_tag[j] == (ex_pc_i >> 6))) begin
        m_ctr[j] = tk ? ((m_ctr[j] == 3) ? 3 : m_ctr[j] + 1) : ((m_ctr[j] == 0) ? 0 : m_ctr[j] - 1);
        if (tk) m_tgt[j] = tgt;
      end else if (tk) begin
        m_v[j] = 1; m_tag[j] = ex_pc_i >> 6; m_tgt[j] = tgt; m_ctr[j] = 2;
      end
    end
    #1;
  endtask

  task automatic set_ex(input logic v, input logic [1:0] t, input logic [2:0] f3,
                        input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] imm, input logic ptk, input logic [31:0] ptgt);
    ex_valid_i = v; ex_type_i = t; ex_funct3_i = f3; ex_pc_i = pc;
    ex_rs1_i = a; ex_rs2_i = b; ex_imm_i = imm;
    ex_pred_taken_i = ptk; ex_pred_target_i = ptgt;
  endtask

  task automatic idle();
    set_ex(1'b0, 2'd0, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
  endtask

  // Forces fetch to addr via a mispredicted JAL resolved at 0x3F0.
  task automatic goto(input logic [31:0] addr);
    stall_i = 1'b0;
    set_ex(1'b1, 2'd2, 3'd0, 32'h3F0, 32'h0, 32'h0, addr - 32'h3F0, 1'b0, 32'h0);
    cycle("goto");
    idle();
    #1;
  endtask

  typedef struct {
    logic        valid;
    logic [1:0]  typ;
    logic [2:0]  f3;
    logic [31:0] pc, rs1, rs2, imm;
    logic        ptk;
    logic [31:0] ptgt;
    logic        exp_flush;
    logic [31:0] exp_link;
  } vec_t;

  vec_t vecs[$];

  initial begin
    vecs.push_back('{1, 2'd1, 3'b000, 32'h400, 32'd7, 32'd7, 32'h10, 1, 32'h410, 0, 32'h404});
    vecs.push_back('{1, 2'd1, 3'b001, 32'h400, 32'd7, 32'd7, 32'h10, 0, 32'h0,   0, 32'h404});
    vecs.push_back('{1, 2'd1, 3'b001, 32'h400, 32'd7, 32'd8, 32'h10, 1, 32'h414, 1, 32'h404});
    vecs.push_back('{1, 2'd1, 3'b100, 32'h408, 32'hFFFF_FFFF, 32'd0, 32'h8, 1, 32'h410, 0, 32'h40C});
    vecs.push_back('{1, 2'd1, 3'b101, 32'h408, 32'hFFFF_FFFF, 32'd0, 32'h8, 1, 32'h410, 1, 32'h40C});
    vecs.push_back('{1, 2'd1, 3'b111, 32'h40C, 32'hFFFF_FFFF, 32'd0, 32'h8, 0, 32'h0,   1, 32'h410});
    vecs.push_back('{1, 2'd1, 3'b010, 32'h40C, 32'd1, 32'd1, 32'h8, 0, 32'h0,   0, 32'h410});
    vecs.push_back('{1, 2'd1, 3'b011, 32'h40C, 32'd1, 32'd1, 32'h8, 1, 32'h414, 1, 32'h410});
    vecs.push_back('{1, 2'd2, 3'b000, 32'hFFFF_FFFC, 32'd0, 32'd0, 32'h8, 1, 32'h4, 0, 32'h0});
    vecs.push_back('{1, 2'd0, 3'b000, 32'h410, 32'd0, 32'd0, 32'h0, 1, 32'h999, 0, 32'h414});
    vecs.push_back('{0, 2'd2, 3'b000, 32'h410, 32'd0, 32'd0, 32'h20, 0, 32'h0, 0, 32'h414});
    vecs.push_back('{1, 2'd3, 3'b000, 32'h414, 32'h1003, 32'd0, 32'h0, 1, 32'h1002, 0, 32'h418});
    vecs.push_back('{1, 2'd3, 3'b000, 32'h414, 32'h1000, 32'd0, 32'hFFFF_FFFF, 1, 32'hFFE, 0, 32'h418});

    // Reset and sequential fetch
    model_reset();
    #1 rst_n = 1'b0;
    #1;
    check("reset.pc", pc_o, RST_PC);
    check("reset.pred_taken", 32'(pred_taken_o), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("seq.pc", pc_o, RST_PC + 32'(4 * i));
      cycle("seq");
    end

    // BEQ taken, unpredicted: flush to 0x60 and allocate
    set_ex(1'b1, 2'd1, 3'b000, 32'h20, 32'd5, 32'd5, 32'h40, 1'b0, 32'h0);
    #1;
    check("beq.flush", 32'(flush_o), 32'h1);
    cycle("beq");
    check("beq.redirect", pc_o, 32'h60);

    // Refetch 0x20: weak-taken entry predicts, then resolves not taken
    goto(32'h20);
    check("refetch.pred_taken", 32'(pred_taken_o), 32'h1);
    check("refetch.pred_target", pred_target_o, 32'h60);
    set_ex(1'b1, 2'd1, 3'b000, 32'h20, 32'd5, 32'd6, 32'h40, 1'b1, 32'h60);
    #1;
    check("nt.flush", 32'(flush_o), 32'h1);
    cycle("nt");
    check("nt.redirect", pc_o, 32'h24);
    goto(32'h20);
    check("weak_nt.pred_taken", 32'(pred_taken_o), 32'h0);

    // JALR with wrong predicted target while stalled
    stall_i = 1'b1;
    set_ex(1'b1, 2'd3, 3'b000, 32'h300, 32'h1003, 32'h0, 32'h0, 1'b1, 32'h1000);
    #1;
    check("jalr.flush", 32'(flush_o), 32'h1);
    check("jalr.link", link_o, 32'h304);
    cycle("jalr");
    check("jalr.redirect", pc_o, 32'h1002);
    stall_i = 1'b0;

    // Signed vs unsigned compare
    set_ex(1'b1, 2'd1, 3'b110, 32'h500, 32'hFFFF_FFFF, 32'd1, 32'h10, 1'b0, 32'h0);
    #1;
    check("bltu.flush", 32'(flush_o), 32'h0);
    cycle("bltu");
    set_ex(1'b1, 2'd1, 3'b100, 32'h500, 32'hFFFF_FFFF, 32'd1, 32'h10, 1'b0, 32'h0);
    #1;
    check("blt.flush", 32'(flush_o), 32'h1);
    cycle("blt");

    // Counter saturation at 11 and at 00
    for (int i = 0; i < 3; i++) begin
      set_ex(1'b1, 2'd1, 3'b000, 32'h44, 32'd1, 32'd1, 32'h20, 1'b0, 32'h0);
      cycle("sat_t");
    end
    set_ex(1'b1, 2'd1, 3'b000, 32'h44, 32'd1, 32'd2, 32'h20, 1'b0, 32'h0);
    cycle("sat_t_nt");
    goto(32'h44);
    check("sat11.pred_taken", 32'(pred_taken_o), 32'h1);
    for (int i = 0; i < 4; i++) begin
      set_ex(1'b1, 2'd1, 3'b000, 32'h44, 32'd1, 32'd2, 32'h20, 1'b0, 32'h0);
      cycle("sat_nt");
    end
    set_ex(1'b1, 2'd1, 3'b000, 32'h44, 32'd1, 32'd1, 32'h20, 1'b0, 32'h0);
    cycle("sat_nt_t");
    goto(32'h44);
    check("sat00.pred_taken", 32'(pred_taken_o), 32'h0);

    // Mid-stream reset with populated BTB
    set_ex(1'b1, 2'd2, 3'b000, 32'h44, 32'd0, 32'd0, 32'h80, 1'b0, 32'h0);
    rst_n = 1'b0;
    #1;
    model_reset();
    check("midrst.pc", pc_o, RST_PC);
    check("midrst.pred_taken", 32'(pred_taken_o), 32'h0);
    @(posedge clk);
    #1;
    check("midrst.hold_pc", pc_o, RST_PC);
    idle();
    rst_n = 1'b1;
    goto(32'h20);
    check("postrst.miss20", 32'(pred_taken_o), 32'h0);
    check("postrst.tgt20", pred_target_o, 32'h0);
    goto(32'h44);
    check("postrst.miss44", 32'(pred_taken_o), 32'h0);

    // Directed table
    foreach (vecs[k]) begin
      set_ex(vecs[k].valid, vecs[k].typ, vecs[k].f3, vecs[k].pc, vecs[k].rs1,
             vecs[k].rs2, vecs[k].imm, vecs[k].ptk, vecs[k].ptgt);
      #1;
      check($sformatf("vec%0d.flush", k), 32'(flush_o), 32'(vecs[k].exp_flush));
      check($sformatf("vec%0d.link", k), link_o, vecs[k].exp_link);
      cycle($sformatf("vec%0d", k));
    end

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      logic [31:0] rpc, rimm;
      rpc  = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2);
      rimm = $urandom_range(0, 1) ? (32'($urandom_range(0, 63)) << 2) : $urandom;
      stall_i = ($urandom_range(0, 3) == 0);
      set_ex($urandom_range(0, 4) != 0, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), rpc,
             $urandom_range(0, 1) ? 32'($urandom_range(0, 3)) : $urandom,
             $urandom_range(0, 1) ? 32'($urandom_range(0, 3)) : $urandom,
             rimm, 1'($urandom_range(0, 1)),
             $urandom_range(0, 1) ? (rpc + rimm) : $urandom);
      cycle("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
